// File: rtl/line_track_controller.sv
// Line-follower motor sequencer: sensor sync/debounce, track/search/fault FSM,
// and an H-bridge output stage with dead time on every direction change.
module line_track_controller #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int LEFT_MS      = 2000,
  parameter int RIGHT_MS     = 4000,
  parameter int DEAD_CYC     = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] IPS,
  input  logic       sw_ON,
  input  logic       speed,
  output logic [3:0] IN,
  output logic [1:0] EN,
  output logic [2:0] state,
  output logic       fault
);
  localparam int PRE   = CLK_HZ / 1000;
  localparam int PW    = $clog2(PRE + 1);
  localparam int MAXMS = (LEFT_MS > RIGHT_MS) ? LEFT_MS : RIGHT_MS;
  localparam int MW    = $clog2(MAXMS + 1);
  localparam int BW    = $clog2(DEBOUNCE_CYC + 1);
  localparam int DW    = $clog2(DEAD_CYC + 1);

  localparam logic [3:0] CMD_FWD  = 4'b1001;
  localparam logic [3:0] CMD_LEFT = 4'b1010;
  localparam logic [3:0] CMD_RGT  = 4'b0101;
  localparam logic [3:0] CMD_STOP = 4'b0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0, TRACK = 3'd1, SEARCH_L = 3'd2, SEARCH_R = 3'd3, FAULT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ips_s1, ips_s2, ips_prev, filt_ips;
  logic            sw_s1, sw_s2;
  logic [BW-1:0]   deb_cnt;
  logic [PW-1:0]   pre;
  logic [MW-1:0]   ms;
  logic            ms_tick, left_done, right_done, lost, in_search;
  logic [3:0]      line_cmd, cmd, cmd_q;
  logic            dead;
  logic [DW-1:0]   dead_cnt;

  // Sync flops for the active-low sensors idle at "no line" so reset can't fake a hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ips_s1   <= 3'b111;
      ips_s2   <= 3'b111;
      ips_prev <= 3'b111;
      filt_ips <= 3'b111;
      deb_cnt  <= '0;
      sw_s1    <= 1'b0;
      sw_s2    <= 1'b0;
    end else begin
      ips_s1   <= IPS;
      ips_s2   <= ips_s1;
      ips_prev <= ips_s2;
      sw_s1    <= sw_ON;
      sw_s2    <= sw_s1;
      if (ips_s2 != ips_prev)
        deb_cnt <= '0;
      else if (deb_cnt == BW'(DEBOUNCE_CYC - 1))
        filt_ips <= ips_s2;
      else
        deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign lost      = (filt_ips == 3'b111);
  assign in_search = (state_q == SEARCH_L) || (state_q == SEARCH_R);
  assign ms_tick   = (pre == PW'(PRE - 1));
  assign left_done  = ms_tick && (ms == MW'(LEFT_MS - 1));
  assign right_done = ms_tick && (ms == MW'(RIGHT_MS - 1));

  always_comb begin
    line_cmd = CMD_STOP;
    if (!filt_ips[1])      line_cmd = CMD_FWD;
    else if (!filt_ips[2]) line_cmd = CMD_LEFT;
    else if (!filt_ips[0]) line_cmd = CMD_RGT;
  end

  // Command follows the next state so the output stage updates on the same edge as the FSM
  always_comb begin
    state_d = state_q;
    cmd     = CMD_STOP;
    case (state_q)
      IDLE:     if (sw_s2) state_d = TRACK;
      TRACK:    if (lost) state_d = SEARCH_L;
      SEARCH_L: if (!lost) state_d = TRACK; else if (left_done) state_d = SEARCH_R;
      SEARCH_R: if (!lost) state_d = TRACK; else if (right_done) state_d = FAULT;
      FAULT:    state_d = FAULT;
      default:  state_d = IDLE;
    endcase
    if (!sw_s2) state_d = IDLE;
    case (state_d)
      TRACK:    cmd = line_cmd;
      SEARCH_L: cmd = CMD_LEFT;
      SEARCH_R: cmd = CMD_RGT;
      default:  cmd = CMD_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre     <= '0;
      ms      <= '0;
    end else begin
      state_q <= state_d;
      if (!in_search || state_d != state_q) begin
        pre <= '0;
        ms  <= '0;
      end else if (ms_tick) begin
        pre <= '0;
        ms  <= ms + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  // Nonzero command changes pass through DEAD_CYC cycles of all-off; stop is immediate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= CMD_STOP;
      IN       <= CMD_STOP;
      dead     <= 1'b0;
      dead_cnt <= '0;
    end else if (cmd != cmd_q) begin
      cmd_q    <= cmd;
      IN       <= CMD_STOP;
      dead     <= (cmd != CMD_STOP);
      dead_cnt <= '0;
    end else if (dead) begin
      if (dead_cnt == DW'(DEAD_CYC - 1)) begin
        dead <= 1'b0;
        IN   <= cmd_q;
      end else begin
        dead_cnt <= dead_cnt + 1'b1;
      end
    end
  end

  assign EN    = (IN != CMD_STOP) ? {2{speed}} : 2'b00;
  assign state = state_q;
  assign fault = (state_q == FAULT);
endmodule

// File: tb/tb_line_track_controller.sv
// Directed bench for line_track_controller with small timing parameters
// (10 cycles/ms, debounce 4, left 3 ms, right 5 ms, dead time 2).
module tb_line_track_controller;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] IPS;
  logic       sw_ON;
  logic       speed;
  logic [3:0] IN;
  logic [1:0] EN;
  logic [2:0] state;
  logic       fault;

  int tests = 0;
  int fails = 0;
  int n;

  line_track_controller #(
    .CLK_HZ(10_000), .DEBOUNCE_CYC(4), .LEFT_MS(3), .RIGHT_MS(5), .DEAD_CYC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .IPS(IPS), .sw_ON(sw_ON), .speed(speed),
    .IN(IN), .EN(EN), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int bound);
    int k;
    k = 0;
    while (state !== s && k < bound) begin
      tick;
      k++;
    end
    chk(tag, {29'd0, state}, {29'd0, s});
  endtask

  initial begin
    rst_n = 1'b0; sw_ON = 1'b0; IPS = 3'b111; speed = 1'b1;
    repeat (3) tick;
    chk("rst_in", IN, 4'b0000);
    chk("rst_en", EN, 2'b00);
    chk("rst_state", state, 3'd0);
    chk("rst_fault", fault, 1'b0);

    // 1: start tracking, forward after dead time, EN follows speed
    rst_n = 1'b1; IPS = 3'b101;
    repeat (10) tick;
    chk("idle_hold", state, 3'd0);
    sw_ON = 1'b1;
    repeat (3) tick;
    chk("t1_state", state, 3'd1);
    chk("t1_dead0", IN, 4'b0000);
    tick;
    chk("t1_dead1", IN, 4'b0000);
    tick;
    chk("t1_fwd", IN, 4'b1001);
    chk("t1_en_hi", EN, 2'b11);
    speed = 1'b0; #1;
    chk("t1_en_lo", EN, 2'b00);
    speed = 1'b1; #1;
    chk("t1_en_hi2", EN, 2'b11);

    // 2: turn left with exact latency and dead time, glitch rejected
    IPS = 3'b011;
    n = 0;
    while (IN == 4'b1001 && n < 30) begin tick; n++; end
    chk("t2_latency", n, 8);
    chk("t2_dead0", IN, 4'b0000);
    chk("t2_dead_en", EN, 2'b00);
    tick;
    chk("t2_dead1", IN, 4'b0000);
    tick;
    chk("t2_left", IN, 4'b1010);
    IPS = 3'b101;
    tick;
    IPS = 3'b011;
    repeat (12) tick;
    chk("t2_glitch", IN, 4'b1010);

    // 3: line lost -> 30 cycles left, 50 cycles right, then latched fault
    IPS = 3'b111;
    wait_state("t3_enter_l", 3'd2, 20);
    chk("t3_in_l", IN, 4'b1010);
    n = 0;
    while (state == 3'd2 && n < 100) begin tick; n++; end
    chk("t3_left_len", n, 30);
    chk("t3_sr_state", state, 3'd3);
    chk("t3_sr_dead", IN, 4'b0000);
    n = 0;
    while (state == 3'd3 && n < 100) begin
      tick; n++;
      if (n == 2) chk("t3_in_r", IN, 4'b0101);
    end
    chk("t3_right_len", n, 50);
    chk("t3_fault_state", state, 3'd4);
    chk("t3_fault", fault, 1'b1);
    chk("t3_fault_in", IN, 4'b0000);
    chk("t3_fault_en", EN, 2'b00);
    IPS = 3'b101;
    repeat (15) tick;
    chk("t3_stay_fault", state, 3'd4);
    chk("t3_stay_in", IN, 4'b0000);

    // 5: switch cycling out of fault, then switch-off while driving
    sw_ON = 1'b0;
    repeat (3) tick;
    chk("t5_idle", state, 3'd0);
    chk("t5_fault_clr", fault, 1'b0);
    sw_ON = 1'b1;
    repeat (3) tick;
    chk("t5_track", state, 3'd1);
    repeat (2) tick;
    chk("t5_fwd", IN, 4'b1001);
    sw_ON = 1'b0;
    repeat (2) tick;
    chk("t5_off_pre", IN, 4'b1001);
    tick;
    chk("t5_off_in", IN, 4'b0000);
    chk("t5_off_en", EN, 2'b00);
    chk("t5_off_state", state, 3'd0);
    sw_ON = 1'b1;
    repeat (5) tick;
    chk("t5_restart", IN, 4'b1001);

    // 4: recovery from right sweep keeps 0101 with no dead time
    IPS = 3'b111;
    wait_state("t4_enter_r", 3'd3, 80);
    repeat (3) tick;
    chk("t4_in_r", IN, 4'b0101);
    IPS = 3'b110;
    wait_state("t4_track", 3'd1, 20);
    chk("t4_keep0", IN, 4'b0101);
    tick;
    chk("t4_keep1", IN, 4'b0101);
    tick;
    chk("t4_keep2", IN, 4'b0101);
    IPS = 3'b101;
    n = 0;
    while (IN == 4'b0101 && n < 20) begin tick; n++; end
    chk("t4_dead0", IN, 4'b0000);
    tick;
    chk("t4_dead1", IN, 4'b0000);
    tick;
    chk("t4_fwd", IN, 4'b1001);

    // 6: async reset mid left sweep, timer restarts from zero
    IPS = 3'b111;
    wait_state("t6_enter_l", 3'd2, 30);
    repeat (10) tick;
    chk("t6_pre_in", IN, 4'b1010);
    rst_n = 1'b0; #1;
    chk("t6_rst_in", IN, 4'b0000);
    chk("t6_rst_en", EN, 2'b00);
    chk("t6_rst_state", state, 3'd0);
    chk("t6_rst_fault", fault, 1'b0);
    tick;
    rst_n = 1'b1;
    wait_state("t6_reenter_l", 3'd2, 20);
    n = 0;
    while (state == 3'd2 && n < 100) begin tick; n++; end
    chk("t6_left_len", n, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
